tug_referee: RTL and testbench

- Game controller for the tug-of-war playfield.
- Turns two raw player keys into single-cycle press events and arbitrates simultaneous presses.
- Moves the lit position along a one-hot light bar, detects a round win when the light is pushed off either end, and keeps per-player scores.
- Sequences round restart and match end; drives the light bar directly.

---
 rtl/tug_referee_if.sv | 24 ++
 rtl/tug_referee.sv | 144 ++++++++++++++
 tb/tb_tug_referee.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/tug_referee_if.sv
// Player/playfield bundle for tug_referee: raw keys in, light bar and
// scoreboard out. master = player/test side, slave = referee side.
interface tug_referee_if #(
   parameter int unsigned NUM_LIGHTS = 9,
   parameter int unsigned SCORE_W    = 3
);
   logic                  key_l;
   logic                  key_r;
   logic [NUM_LIGHTS-1:0] lights;
   logic [SCORE_W-1:0]    score_l;
   logic [SCORE_W-1:0]    score_r;
   logic [1:0]            winner;
   logic                  match_over;

   modport master (
      output key_l, key_r,
      input  lights, score_l, score_r, winner, match_over
   );

   modport slave (
      input  key_l, key_r,
      output lights, score_l, score_r, winner, match_over
   );
endinterface

// File: rtl/tug_referee.sv
// Tug-of-war referee: synchronizes two player keys into press events,
// moves a one-hot light along the bar, scores round wins, and sequences
// hold / restart / match end. Optional macro TUG_HANDICAP_EN makes the
// round loser restart one step closer to winning.
module tug_referee #(
   parameter int unsigned NUM_LIGHTS  = 9,
   parameter int unsigned SCORE_W     = 3,
   parameter int unsigned HOLD_CYCLES = 4
) (
   input logic         clk,
   input logic         reset,
   tug_referee_if.slave bus
);
   localparam int unsigned PW = $clog2(NUM_LIGHTS);
   localparam int unsigned HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

   localparam logic [PW-1:0]      CTR       = PW'(NUM_LIGHTS / 2);
   localparam logic [PW-1:0]      LEFT_END  = PW'(NUM_LIGHTS - 1);
   localparam logic [PW-1:0]      RIGHT_END = '0;
   localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
   localparam logic [HW-1:0]      HOLD_LOAD = HW'(HOLD_CYCLES - 1);
`ifdef TUG_HANDICAP_EN
   localparam logic [PW-1:0]      RESTART_L = CTR - PW'(1);
   localparam logic [PW-1:0]      RESTART_R = CTR + PW'(1);
`else
   localparam logic [PW-1:0]      RESTART_L = CTR;
   localparam logic [PW-1:0]      RESTART_R = CTR;
`endif

   typedef enum logic [1:0] {PLAY, HOLD, DONE} state_t;

   state_t                state_q;
   logic [1:0]            sync_l_q, sync_r_q;
   logic                  prev_l_q, prev_r_q;
   logic [PW-1:0]         pos_q;
   logic [HW-1:0]         hold_q;
   logic [NUM_LIGHTS-1:0] lights_q;
   logic [SCORE_W-1:0]    score_l_q, score_r_q;
   logic [1:0]            winner_q;
   logic                  match_over_q;

   logic                  press_l, press_r;
   logic                  step_l, step_r;
   logic [PW-1:0]         restart_pos;

   function automatic logic [NUM_LIGHTS-1:0] onehot(input logic [PW-1:0] p);
      onehot = NUM_LIGHTS'(1) << p;
   endfunction

   // Two-flop synchronizers plus edge history; reset to 1 so a key held
   // through reset must be released and pressed again before it counts.
   always_ff @(posedge clk) begin
      if (!reset) begin
         sync_l_q <= '1;
         sync_r_q <= '1;
         prev_l_q <= 1'b1;
         prev_r_q <= 1'b1;
      end else begin
         sync_l_q <= {sync_l_q[0], bus.key_l};
         sync_r_q <= {sync_r_q[0], bus.key_r};
         prev_l_q <= sync_l_q[1];
         prev_r_q <= sync_r_q[1];
      end
   end

   // Press detection, cancellation of simultaneous presses, restart choice.
   always_comb begin
      press_l     = sync_l_q[1] & ~prev_l_q;
      press_r     = sync_r_q[1] & ~prev_r_q;
      step_l      = press_l & ~press_r;
      step_r      = press_r & ~press_l;
      restart_pos = (winner_q == 2'b01) ? RESTART_R : RESTART_L;
   end

   // Game FSM with all outputs registered alongside the state.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q      <= PLAY;
         pos_q        <= CTR;
         lights_q     <= onehot(CTR);
         score_l_q    <= '0;
         score_r_q    <= '0;
         winner_q     <= 2'b00;
         match_over_q <= 1'b0;
         hold_q       <= '0;
      end else begin
         case (state_q)
            PLAY: begin
               if (step_l) begin
                  if (pos_q == LEFT_END) begin
                     score_l_q <= (score_l_q == SCORE_MAX) ? score_l_q : score_l_q + SCORE_W'(1);
                     winner_q  <= 2'b10;
                     lights_q  <= '0;
                     hold_q    <= HOLD_LOAD;
                     state_q   <= HOLD;
                  end else begin
                     pos_q    <= pos_q + PW'(1);
                     lights_q <= onehot(pos_q + PW'(1));
                  end
               end else if (step_r) begin
                  if (pos_q == RIGHT_END) begin
                     score_r_q <= (score_r_q == SCORE_MAX) ? score_r_q : score_r_q + SCORE_W'(1);
                     winner_q  <= 2'b01;
                     lights_q  <= '0;
                     hold_q    <= HOLD_LOAD;
                     state_q   <= HOLD;
                  end else begin
                     pos_q    <= pos_q - PW'(1);
                     lights_q <= onehot(pos_q - PW'(1));
                  end
               end
            end
            HOLD: begin
               if (hold_q == '0) begin
                  if ((score_l_q == SCORE_MAX) || (score_r_q == SCORE_MAX)) begin
                     state_q      <= DONE;
                     match_over_q <= 1'b1;
                     lights_q     <= '1;
                  end else begin
                     state_q  <= PLAY;
                     pos_q    <= restart_pos;
                     lights_q <= onehot(restart_pos);
                     winner_q <= 2'b00;
                  end
               end else begin
                  hold_q <= hold_q - HW'(1);
               end
            end
            DONE: begin
               state_q <= DONE;
            end
            default: begin
               state_q <= PLAY;
            end
         endcase
      end
   end

   assign bus.lights     = lights_q;
   assign bus.score_l    = score_l_q;
   assign bus.score_r    = score_r_q;
   assign bus.winner     = winner_q;
   assign bus.match_over = match_over_q;
endmodule

// File: tb/tb_tug_referee.sv
// Scoreboard bench for tug_referee: random key activity and occasional
// resets, expected outputs from a game-rules model queued per clock edge
// and compared by an independent monitor.
module tb_tug_referee;
   localparam int NL = 9;
   localparam int SW = 2;
   localparam int HC = 4;
   localparam int SMAX = (1 << SW) - 1;
   localparam int NCYC = 4000;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   tug_referee_if #(.NUM_LIGHTS(NL), .SCORE_W(SW)) bus ();

   tug_referee #(.NUM_LIGHTS(NL), .SCORE_W(SW), .HOLD_CYCLES(HC)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      logic [NL-1:0] lights;
      logic [SW-1:0] sl;
      logic [SW-1:0] sr;
      logic [1:0]    win;
      logic          mo;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   // Game-rules model. who: 0 none, 1 left, 2 right. phase: 0 play, 1 dark, 2 over.
   int m_pos, m_sl, m_sr, m_who, m_phase, m_dark;
   bit kl_seen[3];   // last three sampled left-key levels, [0] newest
   bit kr_seen[3];

   function automatic int restart_at(input int who);
`ifdef TUG_HANDICAP_EN
      return (who == 1) ? NL / 2 - 1 : NL / 2 + 1;
`else
      return NL / 2;
`endif
   endfunction

   task automatic model_edge(input bit rst_n, input bit kl, input bit kr);
      bit pl, pr;
      if (!rst_n) begin
         m_pos = NL / 2; m_sl = 0; m_sr = 0; m_who = 0; m_phase = 0; m_dark = 0;
         for (int i = 0; i < 3; i++) begin kl_seen[i] = 1'b1; kr_seen[i] = 1'b1; end
      end else begin
         // A press is a key level that became 1, seen two samples late.
         pl = kl_seen[1] && !kl_seen[2];
         pr = kr_seen[1] && !kr_seen[2];
         kl_seen[2] = kl_seen[1]; kl_seen[1] = kl_seen[0]; kl_seen[0] = kl;
         kr_seen[2] = kr_seen[1]; kr_seen[1] = kr_seen[0]; kr_seen[0] = kr;
         if (m_phase == 0) begin
            if (pl && !pr) begin
               if (m_pos == NL - 1) begin
                  m_who = 1; m_sl = (m_sl < SMAX) ? m_sl + 1 : SMAX; m_phase = 1; m_dark = HC;
               end else m_pos++;
            end else if (pr && !pl) begin
               if (m_pos == 0) begin
                  m_who = 2; m_sr = (m_sr < SMAX) ? m_sr + 1 : SMAX; m_phase = 1; m_dark = HC;
               end else m_pos--;
            end
         end else if (m_phase == 1) begin
            m_dark--;
            if (m_dark == 0) begin
               if (m_sl == SMAX || m_sr == SMAX) m_phase = 2;
               else begin m_phase = 0; m_pos = restart_at(m_who); m_who = 0; end
            end
         end
      end
   endtask

   task automatic push_expect();
      exp_t e;
      logic [NL-1:0] one;
      one = 1;
      e.lights = (m_phase == 0) ? (one << m_pos) : (m_phase == 1) ? '0 : '1;
      e.sl     = SW'(m_sl);
      e.sr     = SW'(m_sr);
      e.win    = (m_who == 1) ? 2'b10 : (m_who == 2) ? 2'b01 : 2'b00;
      e.mo     = (m_phase == 2);
      exp_q.push_back(e);
   endtask

   // Apply inputs for the coming rising edge and queue what it must produce.
   task automatic drive(input bit rst_n, input bit kl, input bit kr);
      @(negedge clk);
      reset     = rst_n;
      bus.key_l = kl;
      bus.key_r = kr;
      model_edge(rst_n, kl, kr);
      push_expect();
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, req);
      end
   endtask

   // Monitor: one expectation per rising edge, compared just after it.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL queue_underflow at %0t: got 0 entries expected >=1", $time);
         end else begin
            e = exp_q.pop_front();
            check("lights",     32'(bus.lights),     32'(e.lights));
            check("score_l",    32'(bus.score_l),    32'(e.sl));
            check("score_r",    32'(bus.score_r),    32'(e.sr));
            check("winner",     32'(bus.winner),     32'(e.win));
            check("match_over", 32'(bus.match_over), 32'(e.mo));
         end
      end
   end

   initial begin
      bit kl, kr;
      int bias_l, bias_r, blk;
      // Reset with key_l already held; first edge expectation queued at t=0.
      reset = 1'b0; bus.key_l = 1'b1; bus.key_r = 1'b0;
      model_edge(1'b0, 1'b1, 1'b0);
      push_expect();
      drive(1'b0, 1'b1, 1'b0);
      drive(1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 10; i++) drive(1'b1, 1'b1, 1'b0);
      drive(1'b1, 1'b0, 1'b0);
      // Single press, then held for 20 cycles: one move only.
      for (int i = 0; i < 20; i++) drive(1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++)  drive(1'b1, 1'b0, 1'b0);
      // Simultaneous rise, then rises one cycle apart.
      drive(1'b1, 1'b1, 1'b1);
      for (int i = 0; i < 4; i++)  drive(1'b1, 1'b0, 1'b0);
      drive(1'b1, 1'b1, 1'b0);
      drive(1'b1, 1'b1, 1'b1);
      for (int i = 0; i < 4; i++)  drive(1'b1, 1'b0, 1'b0);

      kl = 1'b0; kr = 1'b0; bias_l = 50; bias_r = 50; blk = 0;
      for (int c = 0; c < NCYC; c++) begin
         if (c % 250 == 0) begin
            bias_l = $urandom_range(10, 90);
            bias_r = 100 - bias_l;
         end
         if ($urandom_range(0, 699) == 0) begin
            for (int j = 0; j < int'($urandom_range(1, 3)); j++) drive(1'b0, kl, kr);
         end
         if (blk == 0) begin
            blk = $urandom_range(1, 4);
            kl  = ($urandom_range(0, 99) < bias_l);
            kr  = ($urandom_range(0, 99) < bias_r);
            if ($urandom_range(0, 1) == 0) begin kl = 1'b0; kr = 1'b0; end
         end
         blk--;
         drive(1'b1, kl, kr);
      end
      @(posedge clk);
      #2;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
